// File: rtl/prime_sieve_ctrl.sv
// Restartable Sieve of Eratosthenes over an external 1-bit flag RAM, compacting
// survivors into a prime-list RAM and then serving indexed lookups from it.
module prime_sieve_ctrl #(
  parameter int N  = 1024,
  parameter int AW = 10,
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] prime_count,
  output logic [AW-1:0] flag_addr,
  output logic          flag_we,
  output logic          flag_wdata,
  input  logic          flag_rdata,
  output logic [CW-1:0] list_addr,
  output logic          list_we,
  output logic [AW-1:0] list_wdata,
  input  logic [AW-1:0] list_rdata,
  input  logic          q_req,
  input  logic [CW-1:0] q_idx,
  output logic          q_ready,
  output logic          q_valid,
  output logic [AW-1:0] q_prime
);

  // One extra bit on j/k so stepping past N never wraps back into the table.
  localparam int XW = AW + 1;
  localparam logic [XW-1:0]   N_X  = XW'(N);
  localparam logic [2*AW-1:0] N_SQ = (2*AW)'(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_OUT_RD,
    S_OUT_CHK,
    S_INNER,
    S_CMP_RD,
    S_CMP_CHK,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] i_q, i_d;
  logic [XW-1:0] j_q, j_d;
  logic [XW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] qaddr_q, qaddr_d;
  logic          pend1_q, pend1_d;
  logic          pend2_q, pend2_d;
  logic          oor1_q, oor1_d;
  logic          oor2_q, oor2_d;
  logic [AW-1:0] q_prime_q, q_prime_d;

  logic [2*AW-1:0] i_sq;
  logic [XW-1:0]   j_step;

  assign i_sq   = {{AW{1'b0}}, i_q} * {{AW{1'b0}}, i_q};
  assign j_step = j_q + {1'b0, i_q};

  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign prime_count = cnt_q;
  assign q_ready     = (state_q == S_DONE) && !pend1_q && !pend2_q;
  assign q_valid     = pend2_q;
  assign q_prime     = q_prime_d;

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    qaddr_d    = qaddr_q;
    pend1_d    = 1'b0;
    pend2_d    = pend1_q;
    oor1_d     = oor1_q;
    oor2_d     = oor1_q;
    q_prime_d  = q_prime_q;
    flag_addr  = '0;
    flag_we    = 1'b0;
    flag_wdata = 1'b0;
    list_addr  = qaddr_q;
    list_we    = 1'b0;
    list_wdata = '0;

    // Lookup result lands two cycles after acceptance; out-of-range reads as 0.
    if (pend2_q) begin
      q_prime_d = oor2_q ? '0 : list_rdata;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          j_d     = '0;
        end
      end

      S_CLEAR: begin
        flag_we    = 1'b1;
        flag_wdata = 1'b1;
        flag_addr  = j_q[AW-1:0];
        j_d        = j_q + XW'(1);
        if (j_q == N_X - XW'(1)) begin
          state_d = S_OUT_RD;
          i_d     = AW'(2);
        end
      end

      S_OUT_RD: begin
        if (i_sq >= N_SQ) begin
          state_d = S_CMP_RD;
          k_d     = XW'(2);
        end else begin
          flag_addr = i_q;
          state_d   = S_OUT_CHK;
        end
      end

      S_OUT_CHK: begin
        if (flag_rdata) begin
          state_d = S_INNER;
          j_d     = i_sq[XW-1:0];
        end else begin
          i_d     = i_q + AW'(1);
          state_d = S_OUT_RD;
        end
      end

      S_INNER: begin
        flag_we    = 1'b1;
        flag_wdata = 1'b0;
        flag_addr  = j_q[AW-1:0];
        j_d        = j_step;
        if (j_step >= N_X) begin
          i_d     = i_q + AW'(1);
          state_d = S_OUT_RD;
        end
      end

      S_CMP_RD: begin
        if (k_q == N_X) begin
          state_d = S_DONE;
        end else begin
          flag_addr = k_q[AW-1:0];
          state_d   = S_CMP_CHK;
        end
      end

      S_CMP_CHK: begin
        if (flag_rdata) begin
          list_we    = 1'b1;
          list_addr  = cnt_q;
          list_wdata = k_q[AW-1:0];
          cnt_d      = cnt_q + CW'(1);
        end
        k_d     = k_q + XW'(1);
        state_d = S_CMP_RD;
      end

      S_DONE: begin
        // A restart takes priority over a lookup offered in the same cycle.
        if (start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          j_d     = '0;
        end else if (q_req && q_ready) begin
          qaddr_d = q_idx;
          pend1_d = 1'b1;
          oor1_d  = (q_idx >= cnt_q);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      qaddr_q   <= '0;
      pend1_q   <= 1'b0;
      pend2_q   <= 1'b0;
      oor1_q    <= 1'b0;
      oor2_q    <= 1'b0;
      q_prime_q <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      qaddr_q   <= qaddr_d;
      pend1_q   <= pend1_d;
      pend2_q   <= pend2_d;
      oor1_q    <= oor1_d;
      oor2_q    <= oor2_d;
      q_prime_q <= q_prime_d;
    end
  end

endmodule
